// File: rtl/up_down_counter_nbit.sv
// N-bit up/down counter with parallel load, programmable top value
// and selectable wrap or saturate behaviour at either boundary.
module up_down_counter_nbit #(
  parameter int WIDTH = 3,
  parameter int MAX   = 2**WIDTH-1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             sat,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             wrap,
  output logic             ovf
);

  localparam logic [WIDTH-1:0] TOP = WIDTH'(MAX);
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic             at_top;
  logic             at_bot;
  logic [WIDTH-1:0] q_nxt;
  logic             wrap_nxt;
  logic             ovf_nxt;

  assign at_top = (q == TOP);
  assign at_bot = (q == '0);
  assign tc     = up ? at_top : at_bot;

  always_comb begin
    q_nxt    = q;
    wrap_nxt = 1'b0;
    ovf_nxt  = ovf;
    if (load) begin
      // Out-of-range loads clamp so q never exceeds TOP.
      q_nxt   = (load_val > TOP) ? TOP : load_val;
      ovf_nxt = 1'b0;
    end else if (en) begin
      if (up) begin
        if (!at_top) begin
          q_nxt = q + ONE;
        end else begin
          ovf_nxt = 1'b1;
          if (!sat) begin
            q_nxt    = '0;
            wrap_nxt = 1'b1;
          end
        end
      end else begin
        if (!at_bot) begin
          q_nxt = q - ONE;
        end else begin
          ovf_nxt = 1'b1;
          if (!sat) begin
            q_nxt    = TOP;
            wrap_nxt = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q    <= '0;
      wrap <= 1'b0;
      ovf  <= 1'b0;
    end else begin
      q    <= q_nxt;
      wrap <= wrap_nxt;
      ovf  <= ovf_nxt;
    end
  end

endmodule
